// File: rtl/alu_issue_stage.sv
// Two-register elastic issue stage around a combinational ALU: stage 1 holds the
// request driving the ALU, stage 2 captures the result plus status flags for writeback.
module alu_issue_stage #(
   parameter int unsigned WIDTH = 3,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH:0]   in_a,
   input  logic [WIDTH:0]   in_b,
   input  logic [1:0]       in_op,
   input  logic             in_ci,
   output logic [WIDTH:0]   alu_a,
   output logic [WIDTH:0]   alu_b,
   output logic [1:0]       alu_op,
   output logic             alu_ci,
   input  logic [WIDTH:0]   alu_out,
   input  logic             alu_cero,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH:0]   res_data,
   output logic [1:0]       res_op,
   output logic             flag_z,
   output logic             flag_n,
   output logic             res_err,
   output logic [CNT_W-1:0] done_cnt
);

   localparam int unsigned DW     = WIDTH + 1;
   localparam logic [1:0]  OP_DIV = 2'b10;
   localparam logic [1:0]  OP_SUB = 2'b11;

   logic s1_valid;
   logic s2_valid;
   logic adv2_c;
   logic accept_c;
   logic capture_c;
   logic consume_c;

   // Stage 1 moves forward whenever stage 2 is empty or draining this cycle.
   assign adv2_c    = s1_valid & (~s2_valid | res_ready);
   assign in_ready  = ~s1_valid | adv2_c;
   // Flush wins over both loads so a flushed cycle never refills a stage.
   assign accept_c  = in_valid & in_ready & ~flush;
   assign capture_c = adv2_c & ~flush;
   assign consume_c = s2_valid & res_ready;
   assign res_valid = s2_valid;

   // Stage 1: request registers feeding the ALU.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid <= 1'b0;
         alu_a    <= '0;
         alu_b    <= '0;
         alu_op   <= '0;
         alu_ci   <= 1'b0;
      end else if (flush) begin
         s1_valid <= 1'b0;
      end else if (accept_c) begin
         s1_valid <= 1'b1;
         alu_a    <= in_a;
         alu_b    <= in_b;
         alu_op   <= in_op;
         alu_ci   <= in_ci;
      end else if (adv2_c) begin
         s1_valid <= 1'b0;
      end
   end

   // Stage 2: result, opcode and sticky status flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s2_valid <= 1'b0;
         res_data <= '0;
         res_op   <= '0;
         flag_z   <= 1'b0;
         flag_n   <= 1'b0;
         res_err  <= 1'b0;
      end else if (flush) begin
         s2_valid <= 1'b0;
      end else if (capture_c) begin
         s2_valid <= 1'b1;
         res_data <= alu_out;
         res_op   <= alu_op;
         flag_z   <= alu_cero;
         flag_n   <= (alu_op == OP_SUB) ? alu_out[WIDTH] : 1'b0;
         res_err  <= (alu_op == OP_DIV) && (alu_b == DW'(0));
      end else if (consume_c) begin
         s2_valid <= 1'b0;
      end
   end

   // Completed-operation counter; flush does not touch it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         done_cnt <= '0;
      end else if (consume_c) begin
         done_cnt <= done_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: an ALU stub closes the loop, and an in-flight queue
// model predicts readiness, result visibility, ordering, flags and the counter.
module tb_alu_issue_stage;

   localparam int unsigned WIDTH = 3;
   localparam int unsigned CNT_W = 8;
   localparam int unsigned DW    = WIDTH + 1;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             flush = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [DW-1:0]    in_a = '0;
   logic [DW-1:0]    in_b = '0;
   logic [1:0]       in_op = '0;
   logic             in_ci = 1'b0;
   logic [DW-1:0]    alu_a;
   logic [DW-1:0]    alu_b;
   logic [1:0]       alu_op;
   logic             alu_ci;
   logic [DW-1:0]    alu_out;
   logic             alu_cero;
   logic             res_valid;
   logic             res_ready = 1'b0;
   logic [DW-1:0]    res_data;
   logic [1:0]       res_op;
   logic             flag_z;
   logic             flag_n;
   logic             res_err;
   logic [CNT_W-1:0] done_cnt;

   alu_issue_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_ci(in_ci),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_ci(alu_ci),
      .alu_out(alu_out), .alu_cero(alu_cero),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_op(res_op),
      .flag_z(flag_z), .flag_n(flag_n), .res_err(res_err),
      .done_cnt(done_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [1:0] op, input logic ci);
      logic [DW-1:0] r;
      case (op)
         2'b00:   r = a + b + DW'(ci);
         2'b01:   r = a * b;
         2'b10:   r = (b == '0) ? '0 : a / b;
         default: r = a - b - DW'(ci);
      endcase
      return r;
   endfunction

   always_comb begin
      alu_out  = alu_f(alu_a, alu_b, alu_op, alu_ci);
      alu_cero = (alu_out == '0);
   end

   typedef struct {
      logic [DW-1:0] data;
      logic [1:0]    op;
      logic          z;
      logic          n;
      logic          err;
      int            age;
   } item_t;

   item_t            q[$];
   item_t            last;
   logic [CNT_W-1:0] m_done;
   int               total = 0;
   int               bad = 0;

   logic [DW-1:0]    snap_data;
   logic             snap_valid, snap_ready, snap_z, snap_n, snap_err;
   logic [1:0]       snap_op;
   logic [CNT_W-1:0] snap_done;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: drive inputs, check outputs against the model, then advance the model.
   task automatic cycle(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [1:0] op, input logic ci, input logic rr, input logic fl);
      item_t it;
      logic  exp_rv, exp_ir, acc, cons;
      @(negedge clk);
      in_valid = v; in_a = a; in_b = b; in_op = op; in_ci = ci;
      res_ready = rr; flush = fl;
      #1;
      exp_ir = !(q.size() == 2 && !rr);
      exp_rv = (q.size() == 2) || (q.size() == 1 && q[0].age >= 1);
      if (exp_rv) last = q[0];
      chk("in_ready", 32'(in_ready), 32'(exp_ir));
      chk("res_valid", 32'(res_valid), 32'(exp_rv));
      chk("res_data", 32'(res_data), 32'(last.data));
      chk("res_op", 32'(res_op), 32'(last.op));
      chk("flag_z", 32'(flag_z), 32'(last.z));
      chk("flag_n", 32'(flag_n), 32'(last.n));
      chk("res_err", 32'(res_err), 32'(last.err));
      chk("done_cnt", 32'(done_cnt), 32'(m_done));
      snap_data = res_data; snap_valid = res_valid; snap_ready = in_ready;
      snap_z = flag_z; snap_n = flag_n; snap_err = res_err; snap_op = res_op;
      snap_done = done_cnt;
      acc  = v && exp_ir && !fl;
      cons = exp_rv && rr;
      @(posedge clk);
      if (cons) m_done = m_done + CNT_W'(1);
      if (fl) begin
         q.delete();
      end else begin
         if (cons) void'(q.pop_front());
         foreach (q[i]) q[i].age++;
         if (acc) begin
            it.data = alu_f(a, b, op, ci);
            it.op   = op;
            it.z    = (it.data == '0);
            it.n    = (op == 2'b11) ? it.data[DW-1] : 1'b0;
            it.err  = (op == 2'b10) && (b == '0);
            it.age  = 0;
            q.push_back(it);
         end
      end
   endtask

   task automatic idle(input int n, input logic rr);
      for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 2'b00, 1'b0, rr, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_res_data", 32'(res_data), 32'd0);
      chk("rst_res_op", 32'(res_op), 32'd0);
      chk("rst_flags", 32'({flag_z, flag_n, res_err}), 32'd0);
      chk("rst_alu", 32'({alu_a, alu_b, alu_op, alu_ci}), 32'd0);
      chk("rst_done", 32'(done_cnt), 32'd0);
      q.delete();
      last = '{data: '0, op: '0, z: 1'b0, n: 1'b0, err: 1'b0, age: 0};
      m_done = '0;
      in_valid = 1'b0; flush = 1'b0; res_ready = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
   endtask

   initial begin
      logic [CNT_W-1:0] d0;
      do_reset();

      // Subtract with positive result, one-cycle latency after accept.
      cycle(1'b1, 4'd5, 4'd3, 2'b11, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, '0, '0, 2'b00, 1'b0, 1'b1, 1'b0);
      chk("lat_valid_early", 32'(snap_valid), 32'd0);
      cycle(1'b0, '0, '0, 2'b00, 1'b0, 1'b1, 1'b0);
      chk("lat_valid", 32'(snap_valid), 32'd1);
      chk("lat_data", 32'(snap_data), 32'd2);
      chk("lat_op", 32'(snap_op), 32'd3);
      chk("lat_flags", 32'({snap_z, snap_n}), 32'd0);

      // Negative subtract.
      cycle(1'b1, 4'd3, 4'd5, 2'b11, 1'b0, 1'b1, 1'b0);
      idle(2, 1'b1);
      chk("neg_data", 32'(snap_data), 32'hE);
      chk("neg_flag", 32'(snap_n), 32'd1);

      // Zero result.
      cycle(1'b1, 4'd0, 4'd0, 2'b00, 1'b0, 1'b1, 1'b0);
      idle(2, 1'b1);
      chk("zero_flag", 32'(snap_z), 32'd1);

      // Divide by zero.
      cycle(1'b1, 4'd6, 4'd0, 2'b10, 1'b0, 1'b1, 1'b0);
      idle(2, 1'b1);
      chk("div0_err", 32'(snap_err), 32'd1);
      idle(1, 1'b1);
      chk("err_persist", 32'(snap_err), 32'd1);

      // Throughput: four back-to-back adds.
      d0 = m_done;
      for (int i = 1; i <= 4; i++) cycle(1'b1, DW'(i), DW'(i), 2'b00, 1'b0, 1'b1, 1'b0);
      idle(3, 1'b1);
      chk("thru_count", 32'(CNT_W'(snap_done - d0)), 32'd4);

      // Backpressure with both stages full, then drain.
      cycle(1'b1, 4'd1, 4'd2, 2'b00, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 4'd3, 4'd4, 2'b00, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 4'd7, 4'd7, 2'b00, 1'b0, 1'b0, 1'b0);
      chk("bp_in_ready", 32'(snap_ready), 32'd0);
      chk("bp_data", 32'(snap_data), 32'd3);
      idle(4, 1'b1);

      // Flush with both stages full; flags keep prior values.
      cycle(1'b1, 4'd2, 4'd3, 2'b11, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 4'd9, 4'd1, 2'b01, 1'b0, 1'b0, 1'b0);
      idle(1, 1'b0);
      cycle(1'b0, '0, '0, 2'b00, 1'b0, 1'b0, 1'b1);
      idle(1, 1'b0);
      chk("flush_valid", 32'(snap_valid), 32'd0);
      chk("flush_flag_n", 32'(snap_n), 32'd1);

      // Counter wrap after 256 consumed results.
      do_reset();
      for (int i = 0; i < 256; i++) cycle(1'b1, DW'(i), 4'd1, 2'b00, 1'b0, 1'b1, 1'b0);
      idle(4, 1'b1);
      chk("wrap_done", 32'(snap_done), 32'd0);

      // Randomized traffic with a mid-stream reset.
      for (int i = 0; i < 2000; i++) begin
         if (i == 1000) do_reset();
         cycle(($urandom_range(9) < 7), DW'($urandom_range(15)),
               ($urandom_range(5) == 0) ? '0 : DW'($urandom_range(15)),
               2'($urandom_range(3)), 1'($urandom_range(1)),
               ($urandom_range(9) < 7), ($urandom_range(49) == 0));
      end
      idle(4, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Elastic two-register pipeline wrapped around the combinational ALU.
- Stage 1 captures an operation request from decode and drives the ALU operand/opcode inputs.
- Stage 2 captures the ALU result and derives status flags, then presents them to writeback.
- Valid/ready handshakes on both sides; sustains one operation per cycle.

Parameters:
- WIDTH, 3, MSB index of data paths; all operands and results are WIDTH+1 bits, matching the ALU.
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of both stages.
- in_valid  input  1  request valid from decode.
- in_ready  output  1  stage can accept the request this cycle.
- in_a  input  WIDTH+1  operand a.
- in_b  input  WIDTH+1  operand b.
- in_op  input  2  opcode: 00 add, 01 mul, 10 div, 11 sub.
- in_ci  input  1  carry-in.
- alu_a, alu_b  output  WIDTH+1  stage-1 operands driven to the ALU.
- alu_op  output  2  stage-1 opcode driven to the ALU.
- alu_ci  output  1  stage-1 carry-in driven to the ALU.
- alu_out  input  WIDTH+1  ALU result (combinational from alu_*).
- alu_cero  input  1  ALU zero flag.
- res_valid  output  1  stage-2 result valid.
- res_ready  input  1  writeback accepts the result.
- res_data  output  WIDTH+1  registered result.
- res_op  output  2  opcode of the result.
- flag_z  output  1  zero flag of the last captured result.
- flag_n  output  1  negative flag of the last captured result.
- res_err  output  1  divide-by-zero marker of the result.
- done_cnt  output  CNT_W  count of results consumed by writeback.

Behaviour:
- Reset (rst=0, async): s1_valid=0, s2_valid=0; all alu_* outputs, res_data, res_op, flag_z, flag_n, res_err and done_cnt are 0. in_ready=1 once reset is released.
- Handshake definitions:
  - adv2 = s1_valid & (~s2_valid | res_ready).
  - in_ready = ~s1_valid | adv2. It is purely combinational and must not depend on in_valid.
  - Accept = in_valid & in_ready.
- Stage 1:
  - On accept, load a, b, op and ci, and set s1_valid=1.
  - Else if adv2, clear s1_valid.
  - Registers hold their values while stalled. alu_* always reflect the stage-1 registers.
- Stage 2:
  - On adv2, load res_data=alu_out, res_op=alu_op and s2_valid=1.
  - On the same edge, load the flags:
    - flag_z = alu_cero.
    - flag_n = alu_out[WIDTH] when alu_op==11, else 0.
    - res_err = (alu_op==10 and alu_b==0).
  - Else if res_valid & res_ready, clear s2_valid.
- Flags persist:
  - flag_z, flag_n and res_err change only on adv2.
  - They hold after the result is consumed, until the next capture.
- Latency and throughput:
  - Request accepted at edge k gives res_valid=1 after edge k+1.
  - Back-to-back accepts with res_ready=1 produce one result per cycle.
- Backpressure:
  - With res_ready=0 and both stages full, in_ready=0 and all registers hold.
  - Nothing is dropped or duplicated.
- Simultaneous consume and capture: when s2 is consumed and adv2 loads a new result on the same edge, s2_valid stays 1 and the new data appears.
- done_cnt increments on each res_valid & res_ready and wraps from 2^CNT_W-1 to 0. It is unaffected by flush.
- flush (sync) clears s1_valid and s2_valid on the next edge. Data registers and flags hold; accept and adv2 are suppressed that cycle.
- Reset mid-operation: both stages are discarded immediately and no result is emitted.
- Arithmetic: the result width is WIDTH+1 and overflow truncation is the ALU's. This stage does not alter alu_out.

Test Plan:
- Reset check: rst=0 mid-stream -> all outputs 0 at once; in_ready=1 after release.
- Latency and flags: a=5, b=3, op=11, ci=0, res_ready=1 -> one cycle after accept, res_data=2, flag_z=0, flag_n=0, res_op=11.
- Negative flag: a=3, b=5, op=11 -> res_data=4'b1110, flag_n=1.
- Zero flag: a=0, b=0, op=00 -> res_data=0, flag_z=1.
- Divide-by-zero: a=6, b=0, op=10 -> res_err=1.
- Throughput: 4 back-to-back adds (1+1, 2+2, 3+3, 4+4) with res_ready=1 -> results 2, 4, 6, 8 on consecutive cycles; done_cnt=4.
- Backpressure: res_ready=0 after two accepts -> in_ready=0, res_data held. Raise res_ready -> both results are delivered in order with no loss.
- Flush: flush with both stages full -> res_valid=0 next cycle; flags retain their prior values.
- Counter wrap: 256 consumed results -> done_cnt=0.
